sd_cmd_seq: RTL and testbench

//  SD-card SPI-mode command sequencer, directly upstream of the byte-level SPI engine.

---
 rtl/sd_cmd_seq.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_sd_cmd_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq - SD-card SPI-mode command sequencer.
// Sits in front of a byte-level SPI engine and drives its register bus to
// frame a 6-byte command, poll for the R1 response and optionally read a
// single 512-byte data block (plus its 2-byte CRC, which is discarded).
// Data bytes are streamed out with a per-byte strobe and index.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   cmd_start                  1-cycle request, accepted only in IDLE
//   cmd_idx/cmd_arg/cmd_crc    command fields, latched on accept
//   rd_block                   read a data block after R1 == 8'h00
//   busy, done                 busy from accept to the done pulse
//   r1, err                    last R1 and completion status
//   data_valid/byte/idx        streamed block data
//   spi_enable/rnw/addr/din    engine register bus (write-only accesses)
//   spi_dout                   byte received by the engine
module sd_cmd_seq #(
    parameter int INIT_CYCLES = 22600,
    parameter int BYTE_CYCLES = 18,
    parameter int NCR_MAX     = 16,
    parameter int TOKEN_MAX   = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_idx,
    input  logic [31:0] cmd_arg,
    input  logic [6:0]  cmd_crc,
    input  logic        rd_block,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic [1:0]  err,
    output logic        data_valid,
    output logic [7:0]  data_byte,
    output logic [8:0]  data_idx,
    output logic        spi_enable,
    output logic        spi_rnw,
    output logic [2:0]  spi_addr,
    output logic [7:0]  spi_din,
    input  logic [7:0]  spi_dout
);

    localparam int CW = $clog2(((INIT_CYCLES > BYTE_CYCLES) ? INIT_CYCLES : BYTE_CYCLES) + 1);
    localparam int BW = ($clog2(TOKEN_MAX + 1) > 10) ? $clog2(TOKEN_MAX + 1) : 10;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_IDLE, S_CS_LOW, S_SEND, S_R1_POLL, S_TOKEN_POLL,
        S_DATA, S_CRC, S_TRAIL, S_CS_HIGH, S_DONE
    } state_t;

    // Command frame byte n: {01,idx}, arg MSB first, {crc,1}.
    function automatic logic [7:0] cmd_byte(input logic [2:0] sel, input logic [5:0] idx,
                                            input logic [31:0] arg, input logic [6:0] crc);
        logic [7:0] b;
        case (sel)
            3'd0:    b = {2'b01, idx};
            3'd1:    b = arg[31:24];
            3'd2:    b = arg[23:16];
            3'd3:    b = arg[15:8];
            3'd4:    b = arg[7:0];
            3'd5:    b = {crc, 1'b1};
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    state_t      state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;      // INIT_WAIT clocks, or clocks since the strobe + 1
    logic [BW-1:0] bcnt_r, bcnt_s;    // byte / poll number within the current state
    logic [5:0]  idx_r, idx_s;
    logic [31:0] arg_r, arg_s;
    logic [6:0]  crc_r, crc_s;
    logic        rdb_r, rdb_s;
    logic        busy_r, busy_s, done_r, done_s;
    logic [7:0]  r1_r, r1_s;
    logic [1:0]  err_r, err_s;
    logic        dv_r, dv_s;
    logic [7:0]  db_r, db_s;
    logic [8:0]  didx_r, didx_s;
    logic        en_r, en_s, strobe_s;
    logic [2:0]  addr_r, addr_s;
    logic [7:0]  din_r, din_s;
    logic        sample_s;

    // cnt_r == BYTE_CYCLES is the clock BYTE_CYCLES-1 after the visible strobe.
    assign sample_s = (cnt_r == CW'(BYTE_CYCLES));

    // Next-state, counters and next values of all registered outputs.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        bcnt_s   = bcnt_r;
        idx_s    = idx_r;
        arg_s    = arg_r;
        crc_s    = crc_r;
        rdb_s    = rdb_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        r1_s     = r1_r;
        err_s    = err_r;
        dv_s     = 1'b0;
        db_s     = db_r;
        didx_s   = didx_r;
        strobe_s = 1'b0;
        case (state_r)
            S_INIT_WAIT: begin
                if (cnt_r == CW'(INIT_CYCLES - 1)) begin
                    state_s = S_IDLE;
                    cnt_s   = '0;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s  = cnt_r + CW'(1);
                    busy_s = 1'b1;
                end
            end
            S_IDLE: begin
                busy_s = 1'b0;
                if (cmd_start) begin
                    idx_s   = cmd_idx;
                    arg_s   = cmd_arg;
                    crc_s   = cmd_crc;
                    rdb_s   = rd_block;
                    busy_s  = 1'b1;
                    r1_s    = 8'hFF;
                    err_s   = 2'b00;
                    state_s = S_CS_LOW;
                    cnt_s   = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            // CS accesses: strobe, then one clock gap before the next access.
            S_CS_LOW, S_CS_HIGH: begin
                if (cnt_r == CW'(0)) begin
                    strobe_s = 1'b1;
                    cnt_s    = CW'(1);
                end else if (state_r == S_CS_LOW) begin
                    state_s = S_SEND;
                    cnt_s   = '0;
                    bcnt_s  = '0;
                end else begin
                    state_s = S_DONE;
                    cnt_s   = '0;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                end
            end
            S_SEND, S_R1_POLL, S_TOKEN_POLL, S_DATA, S_CRC, S_TRAIL: begin
                if (cnt_r == CW'(0)) begin
                    strobe_s = 1'b1;
                    cnt_s    = CW'(1);
                end else if (!sample_s) begin
                    cnt_s = cnt_r + CW'(1);
                end else begin
                    // Sample clock: decide, and issue the next strobe right away.
                    strobe_s = 1'b1;
                    cnt_s    = CW'(1);
                    bcnt_s   = bcnt_r + BW'(1);
                    case (state_r)
                        S_SEND: begin
                            if (bcnt_r == BW'(5)) begin
                                state_s = S_R1_POLL;
                                bcnt_s  = '0;
                            end else begin
                                state_s = S_SEND;
                            end
                        end
                        S_R1_POLL: begin
                            if (!spi_dout[7]) begin
                                r1_s   = spi_dout;
                                bcnt_s = '0;
                                if (!rdb_r) begin
                                    state_s = S_TRAIL;
                                end else if (spi_dout == 8'h00) begin
                                    state_s = S_TOKEN_POLL;
                                end else begin
                                    err_s   = 2'b11;
                                    state_s = S_TRAIL;
                                end
                            end else if (bcnt_r == BW'(NCR_MAX - 1)) begin
                                err_s   = 2'b01;
                                r1_s    = 8'hFF;
                                state_s = S_TRAIL;
                            end else begin
                                state_s = S_R1_POLL;
                            end
                        end
                        S_TOKEN_POLL: begin
                            if (spi_dout == 8'hFE) begin
                                state_s = S_DATA;
                                bcnt_s  = '0;
                            end else if ((spi_dout != 8'hFF) || (bcnt_r == BW'(TOKEN_MAX - 1))) begin
                                err_s   = 2'b10;
                                state_s = S_TRAIL;
                            end else begin
                                state_s = S_TOKEN_POLL;
                            end
                        end
                        S_DATA: begin
                            dv_s   = 1'b1;
                            db_s   = spi_dout;
                            didx_s = bcnt_r[8:0];
                            if (bcnt_r == BW'(511)) begin
                                state_s = S_CRC;
                                bcnt_s  = '0;
                            end else begin
                                state_s = S_DATA;
                            end
                        end
                        S_CRC: begin
                            if (bcnt_r == BW'(1)) begin
                                state_s = S_TRAIL;
                            end else begin
                                state_s = S_CRC;
                            end
                        end
                        S_TRAIL: begin
                            // CS high goes through its own idle-counted access.
                            strobe_s = 1'b0;
                            cnt_s    = '0;
                            state_s  = S_CS_HIGH;
                        end
                        default: begin
                            state_s = S_TRAIL;
                        end
                    endcase
                end
            end
            S_DONE: begin
                // done is visible here, so a simultaneous cmd_start is not accepted.
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s = S_INIT_WAIT;
                cnt_s   = '0;
                busy_s  = 1'b1;
            end
        endcase
    end

    // Engine bus values for the access issued this clock (addr chosen by the target state).
    always_comb begin
        en_s = strobe_s;
        if (strobe_s) begin
            case (state_s)
                S_SEND: begin
                    addr_s = 3'd0;
                    din_s  = cmd_byte(bcnt_s[2:0], idx_r, arg_r, crc_r);
                end
                S_CS_LOW: begin
                    addr_s = 3'd4;
                    din_s  = 8'h00;
                end
                S_CS_HIGH: begin
                    addr_s = 3'd3;
                    din_s  = 8'h00;
                end
                default: begin
                    addr_s = 3'd1;
                    din_s  = 8'h00;
                end
            endcase
        end else begin
            addr_s = 3'd0;
            din_s  = 8'h00;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_INIT_WAIT;
            cnt_r   <= '0;
            bcnt_r  <= '0;
            idx_r   <= 6'd0;
            arg_r   <= 32'd0;
            crc_r   <= 7'd0;
            rdb_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            r1_r    <= 8'hFF;
            err_r   <= 2'b00;
            dv_r    <= 1'b0;
            db_r    <= 8'h00;
            didx_r  <= 9'd0;
            en_r    <= 1'b0;
            addr_r  <= 3'd0;
            din_r   <= 8'h00;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bcnt_r  <= bcnt_s;
            idx_r   <= idx_s;
            arg_r   <= arg_s;
            crc_r   <= crc_s;
            rdb_r   <= rdb_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            r1_r    <= r1_s;
            err_r   <= err_s;
            dv_r    <= dv_s;
            db_r    <= db_s;
            didx_r  <= didx_s;
            en_r    <= en_s;
            addr_r  <= addr_s;
            din_r   <= din_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign r1         = r1_r;
    assign err        = err_r;
    assign data_valid = dv_r;
    assign data_byte  = db_r;
    assign data_idx   = didx_r;
    assign spi_enable = en_r;
    assign spi_rnw    = 1'b0;
    assign spi_addr   = addr_r;
    assign spi_din    = din_r;

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Testbench for sd_cmd_seq: a behavioural SPI engine answers bus accesses
// (response valid only from the clock BYTE_CYCLES-1 after each strobe),
// and scoreboards hold the expected command bytes and block data.
module tb_sd_cmd_seq;

    localparam int BYTE = 18;
    localparam int NCR  = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic [5:0]  cmd_idx = 6'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic [6:0]  cmd_crc = 7'd0;
    logic        rd_block = 1'b0;
    logic        busy, done, data_valid, spi_enable, spi_rnw;
    logic [7:0]  r1, data_byte, spi_din;
    logic [7:0]  spi_dout = 8'hFF;
    logic [1:0]  err;
    logic [8:0]  data_idx;
    logic [2:0]  spi_addr;

    sd_cmd_seq #(.INIT_CYCLES(100), .BYTE_CYCLES(BYTE), .NCR_MAX(NCR), .TOKEN_MAX(4096)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_idx(cmd_idx),
        .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .rd_block(rd_block), .busy(busy),
        .done(done), .r1(r1), .err(err), .data_valid(data_valid), .data_byte(data_byte),
        .data_idx(data_idx), .spi_enable(spi_enable), .spi_rnw(spi_rnw),
        .spi_addr(spi_addr), .spi_din(spi_din), .spi_dout(spi_dout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_str = 0, n_a1 = 0, n_a3 = 0, n_a4 = 0, n_dv = 0;

    // Engine model configuration for the current command.
    int         m_r1_at = 0;
    logic [7:0] m_r1_val = 8'h00;
    bit         m_rd = 1'b0;
    int         m_tok_at = 0;
    logic [7:0] m_tok_val = 8'hFE;

    logic [7:0]  din_q[$];
    logic [16:0] data_q[$];   // {idx, byte}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_resp(input int jj);
        int t, d;
        if (jj < m_r1_at) return 8'hFF;
        if (jj == m_r1_at) return m_r1_val;
        if (!m_rd) return 8'hFF;
        t = jj - m_r1_at - 1;
        if (t < m_tok_at) return 8'hFF;
        if (t == m_tok_at) return m_tok_val;
        d = t - m_tok_at - 1;
        if (d < 512) return d[7:0];
        return 8'hFF;
    endfunction

    always @(posedge clk) cyc++;

    // Engine model and output monitor.
    int         k = 0, j = 0, prev_cyc = 0;
    bit         prev_byte = 1'b0;
    logic [7:0] resp = 8'hFF;
    logic [16:0] exp_d;
    always @(negedge clk) begin
        if (reset_n && spi_enable) begin
            n_str++;
            check("spi_rnw", {31'd0, spi_rnw}, 32'd0);
            if (prev_byte) check("strobe_gap_ok", {31'd0, (cyc - prev_cyc) >= BYTE}, 32'd1);
            prev_byte = (spi_addr == 3'd0) || (spi_addr == 3'd1);
            prev_cyc  = cyc;
            k = 0;
            spi_dout = 8'h3C;
            resp = 8'hFF;
            case (spi_addr)
                3'd4: begin n_a4++; j = 0; end
                3'd3: n_a3++;
                3'd0: begin
                    if (din_q.size() == 0) check("din_extra", {24'd0, spi_din}, 32'hFFFF_FFFF);
                    else check("spi_din", {24'd0, spi_din}, {24'd0, din_q.pop_front()});
                end
                3'd1: begin n_a1++; resp = model_resp(j); j++; end
                default: check("spi_addr", {29'd0, spi_addr}, 32'd1);
            endcase
        end else begin
            k++;
            if (k == BYTE - 1) spi_dout = resp;
        end
        if (reset_n && data_valid) begin
            n_dv++;
            if (data_q.size() == 0) begin
                check("data_extra", {23'd0, data_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_d = data_q.pop_front();
                check("data_idx", {23'd0, data_idx}, {23'd0, exp_d[16:8]});
                check("data_byte", {24'd0, data_byte}, {24'd0, exp_d[7:0]});
            end
        end
    end

    task automatic clr_counts();
        n_str = 0; n_a1 = 0; n_a3 = 0; n_a4 = 0; n_dv = 0;
    endtask

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input logic [6:0] crc, input logic rd);
        repeat (2) @(negedge clk);
        clr_counts();
        din_q.push_back({2'b01, idx});
        din_q.push_back(arg[31:24]);
        din_q.push_back(arg[23:16]);
        din_q.push_back(arg[15:8]);
        din_q.push_back(arg[7:0]);
        din_q.push_back({crc, 1'b1});
        cmd_idx = idx; cmd_arg = arg; cmd_crc = crc; rd_block = rd;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (done !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    int a4_save;

    initial begin
        // Reset values and INIT_WAIT.
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_r1", {24'd0, r1}, 32'hFF);
        check("rst_err", {30'd0, err}, 32'd0);
        check("rst_en", {31'd0, spi_enable}, 32'd0);
        reset_n = 1'b1;
        for (int c = 1; c <= 105; c++) begin
            @(negedge clk);
            if (c == 1)   check("init_busy_first", {31'd0, busy}, 32'd1);
            if (c == 49)  cmd_start = 1'b1;
            if (c == 50)  cmd_start = 1'b0;
            if (c == 99)  check("init_busy_last", {31'd0, busy}, 32'd1);
            if (c == 100) check("init_idle", {31'd0, busy}, 32'd0);
        end
        check("init_no_strobes", n_str, 32'd0);
        check("init_start_dropped", {31'd0, busy}, 32'd0);

        // CMD0, R1=0x01 on the second poll; cmd_start during done is ignored.
        m_r1_at = 1; m_r1_val = 8'h01; m_rd = 1'b0;
        start_cmd(6'd0, 32'd0, 7'h4A, 1'b0);
        wait_done(2000);
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        a4_save = n_a4;
        repeat (10) @(negedge clk);
        check("cmd0_r1", {24'd0, r1}, 32'h01);
        check("cmd0_err", {30'd0, err}, 32'd0);
        check("cmd0_din_all_sent", din_q.size(), 32'd0);
        check("cmd0_polls", n_a1, 32'd3);
        check("cmd0_cs_low", n_a4, 32'd1);
        check("cmd0_cs_high", n_a3, 32'd1);
        check("done_start_ignored_busy", {31'd0, busy}, 32'd0);
        check("done_start_ignored_cs", n_a4, a4_save);

        // CMD17 block read: R1=00, token after 3 polls, data i[7:0].
        m_r1_at = 0; m_r1_val = 8'h00; m_rd = 1'b1; m_tok_at = 3; m_tok_val = 8'hFE;
        for (int i = 0; i < 512; i++) data_q.push_back({i[8:0], i[7:0]});
        start_cmd(6'd17, 32'h0000_1234, 7'h2A, 1'b1);
        repeat (200) @(negedge clk);
        cmd_idx = 6'd5;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        wait_done(12000);
        check("cmd17_err", {30'd0, err}, 32'd0);
        check("cmd17_r1", {24'd0, r1}, 32'h00);
        check("cmd17_dv_count", n_dv, 32'd512);
        check("cmd17_data_left", data_q.size(), 32'd0);
        check("cmd17_polls", n_a1, 32'd520);
        check("cmd17_single_cs_low", n_a4, 32'd1);

        // Card never answers.
        m_r1_at = 100000; m_rd = 1'b0;
        start_cmd(6'd8, 32'h0000_01AA, 7'h43, 1'b0);
        wait_done(2000);
        check("ncr_err", {30'd0, err}, 32'd1);
        check("ncr_r1", {24'd0, r1}, 32'hFF);
        check("ncr_polls", n_a1, NCR + 1);
        check("ncr_cs_high", n_a3, 32'd1);

        // Error token 0x05 after R1=00.
        m_r1_at = 0; m_r1_val = 8'h00; m_rd = 1'b1; m_tok_at = 0; m_tok_val = 8'h05;
        start_cmd(6'd17, 32'd0, 7'h00, 1'b1);
        wait_done(2000);
        check("tok_err", {30'd0, err}, 32'd2);
        check("tok_no_data", n_dv, 32'd0);
        check("tok_cs_high", n_a3, 32'd1);
        check("tok_polls", n_a1, 32'd3);

        // Nonzero R1 with rd_block.
        m_r1_at = 0; m_r1_val = 8'h04; m_rd = 1'b1;
        start_cmd(6'd17, 32'd0, 7'h00, 1'b1);
        wait_done(2000);
        check("r1nz_err", {30'd0, err}, 32'd3);
        check("r1nz_r1", {24'd0, r1}, 32'h04);
        check("r1nz_polls", n_a1, 32'd2);

        // Reset mid-transfer aborts immediately, then the block recovers.
        m_r1_at = 100000; m_rd = 1'b0;
        start_cmd(6'd1, 32'd0, 7'h00, 1'b0);
        repeat (150) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_en", {31'd0, spi_enable}, 32'd0);
        check("abort_r1", {24'd0, r1}, 32'hFF);
        din_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (101) @(negedge clk);
        check("reinit_idle", {31'd0, busy}, 32'd0);
        m_r1_at = 0; m_r1_val = 8'h01; m_rd = 1'b0;
        start_cmd(6'd0, 32'd0, 7'h4A, 1'b0);
        wait_done(2000);
        check("recover_r1", {24'd0, r1}, 32'h01);
        check("recover_err", {30'd0, err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
